// File: rtl/chan_fifo_writer.sv
// Channel packetizer: packs I/Q samples into two ping-pong RAM slots, then
// writes the timestamp and header words and hands the slot to the consumer.
module chan_fifo_writer #(
  parameter int         PKT_SAMPLES = 126,
  parameter logic [4:0] CHANNEL     = 5'd0
) (
  input  logic        rx_clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        rx_strobe,
  input  logic [15:0] rx_i,
  input  logic [15:0] rx_q,
  input  logic [31:0] adc_time,
  input  logic [1:0]  slot_free,
  output logic [7:0]  ram_wraddr,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  output logic        pkt_ready,
  output logic        pkt_slot,
  output logic        overrun,
  output logic [15:0] debug
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, FILL = 3'd1, WR_TS = 3'd2, WR_HDR = 3'd3, COMMIT = 3'd4
  } state_t;

  localparam logic [6:0] LAST = 7'(PKT_SAMPLES);

  state_t      state_q;
  logic        cur_q, ovr_q, eob_q, sob_q, pkt_sob_q, pend_q;
  logic [1:0]  busy_q, busy_d;
  logic [6:0]  cnt_q;
  logic [31:0] ts_q, pend_smp_q, pend_ts_q;
  logic [7:0]  wraddr_q;
  logic [31:0] wdata_q;
  logic        wren_q, rdy_q, slot_q, ovf_q;
  logic [15:0] debug_q;

  logic        live, go, accept, park;
  logic [31:0] go_smp, go_ts, hdr;

  always_comb begin
    live   = rx_strobe && enable;
    // IDLE treats a parked strobe exactly like a live one
    go     = pend_q || live;
    go_smp = pend_q ? pend_smp_q : {rx_q, rx_i};
    go_ts  = pend_q ? pend_ts_q : adc_time;
    accept = (state_q == IDLE) && go && !busy_q[cur_q];
    park   = live && (state_q == WR_TS || state_q == WR_HDR || state_q == COMMIT);
    busy_d = busy_q & ~slot_free;
    if (accept) busy_d[cur_q] = 1'b1;
    hdr    = {3'b000, pkt_sob_q, eob_q, ovr_q, 5'd0, CHANNEL, 7'd0, cnt_q, 2'b00};
  end

  always_ff @(posedge rx_clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_q      <= 1'b0;
      busy_q     <= 2'b00;
      cnt_q      <= 7'd0;
      ovr_q      <= 1'b0;
      eob_q      <= 1'b0;
      sob_q      <= 1'b1;
      pkt_sob_q  <= 1'b0;
      pend_q     <= 1'b0;
      ts_q       <= 32'd0;
      pend_smp_q <= 32'd0;
      pend_ts_q  <= 32'd0;
      wraddr_q   <= 8'd0;
      wdata_q    <= 32'd0;
      wren_q     <= 1'b0;
      rdy_q      <= 1'b0;
      slot_q     <= 1'b0;
      ovf_q      <= 1'b0;
      debug_q    <= 16'd0;
    end else begin
      wren_q  <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= busy_d;
      debug_q <= {state_q, busy_q, cur_q, cnt_q, enable, rx_strobe, wren_q};
      if (park) begin
        pend_q     <= 1'b1;
        pend_smp_q <= {rx_q, rx_i};
        pend_ts_q  <= adc_time;
      end
      case (state_q)
        IDLE: begin
          pend_q <= 1'b0;
          if (accept) begin
            wren_q    <= 1'b1;
            wraddr_q  <= {cur_q, 7'd2};
            wdata_q   <= go_smp;
            ts_q      <= go_ts;
            cnt_q     <= 7'd1;
            pkt_sob_q <= sob_q;
            sob_q     <= 1'b0;
            state_q   <= (LAST == 7'd1) ? WR_TS : FILL;
          end else if (go) begin
            ovr_q <= 1'b1;
            ovf_q <= 1'b1;
          end
        end
        FILL: begin
          if (live) begin
            wren_q   <= 1'b1;
            wraddr_q <= {cur_q, 7'(cnt_q + 7'd2)};
            wdata_q  <= {rx_q, rx_i};
            cnt_q    <= cnt_q + 7'd1;
            if (cnt_q + 7'd1 == LAST) state_q <= WR_TS;
          end else if (!enable && !rx_strobe) begin
            eob_q   <= 1'b1;
            state_q <= WR_TS;
          end
        end
        WR_TS: begin
          wren_q   <= 1'b1;
          wraddr_q <= {cur_q, 7'd1};
          wdata_q  <= ts_q;
          state_q  <= WR_HDR;
        end
        WR_HDR: begin
          wren_q   <= 1'b1;
          wraddr_q <= {cur_q, 7'd0};
          wdata_q  <= hdr;
          state_q  <= COMMIT;
        end
        COMMIT: begin
          rdy_q   <= 1'b1;
          slot_q  <= cur_q;
          cur_q   <= ~cur_q;
          ovr_q   <= 1'b0;
          eob_q   <= 1'b0;
          ovf_q   <= 1'b0;
          cnt_q   <= 7'd0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // any cycle with enable low re-arms start-of-burst for the next packet
      if (!enable) sob_q <= 1'b1;
    end
  end

  assign ram_wraddr = wraddr_q;
  assign ram_data   = wdata_q;
  assign ram_wren   = wren_q;
  assign pkt_ready  = rdy_q;
  assign pkt_slot   = slot_q;
  assign overrun    = ovf_q;
  assign debug      = debug_q;
endmodule

// File: tb/tb_chan_fifo_writer.sv
// Bench for chan_fifo_writer (4-sample packets): directed scenarios plus
// randomized bursts checked against a packet-level reference model.
module tb_chan_fifo_writer;
  localparam int         PK = 4;
  localparam logic [4:0] CH = 5'd0;

  logic        rx_clock, reset, enable, rx_strobe;
  logic [15:0] rx_i, rx_q;
  logic [31:0] adc_time;
  logic [1:0]  slot_free, auto_fv, man_fv;
  logic [7:0]  ram_wraddr;
  logic [31:0] ram_data;
  logic        ram_wren, pkt_ready, pkt_slot, overrun, auto_free;
  logic [15:0] debug;

  typedef struct { int cyc; logic [7:0] a; logic [31:0] d; } wr_t;
  typedef struct { int cyc; logic s; } rdy_t;
  wr_t  wr_q[$];
  rdy_t rdy_q[$];
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;

  chan_fifo_writer #(.PKT_SAMPLES(PK), .CHANNEL(CH)) dut (
    .rx_clock(rx_clock), .reset(reset), .enable(enable), .rx_strobe(rx_strobe),
    .rx_i(rx_i), .rx_q(rx_q), .adc_time(adc_time), .slot_free(slot_free),
    .ram_wraddr(ram_wraddr), .ram_data(ram_data), .ram_wren(ram_wren),
    .pkt_ready(pkt_ready), .pkt_slot(pkt_slot), .overrun(overrun), .debug(debug)
  );

  initial rx_clock = 1'b0;
  always #5 rx_clock = ~rx_clock;
  always @(posedge rx_clock) cyc <= cyc + 1;

  assign slot_free = auto_fv | man_fv;

  // Consumer: releases each completed slot one cycle after pkt_ready.
  initial begin
    auto_fv = 2'b00;
    forever begin
      @(negedge rx_clock);
      auto_fv = (auto_free && pkt_ready) ? (2'b01 << pkt_slot) : 2'b00;
    end
  end

  always @(negedge rx_clock) begin
    if (!reset) begin
      if (ram_wren) wr_q.push_back('{cyc, ram_wraddr, ram_data});
      if (pkt_ready) rdy_q.push_back('{cyc, pkt_slot});
    end
  end

  // Strobe sampled 'gap' edges after the call; n = cycle the strobe is high.
  task automatic strobe(input logic [15:0] i, input logic [15:0] q, input logic [31:0] ts,
                        input int gap, output int n);
    repeat (gap - 1) @(posedge rx_clock);
    #1 rx_i = i; rx_q = q; adc_time = ts; rx_strobe = 1'b1; n = cyc;
    @(posedge rx_clock);
    #1 rx_strobe = 1'b0;
  endtask

  task automatic free_slots(input logic [1:0] m);
    man_fv = m;
    @(posedge rx_clock);
    #1 man_fv = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge rx_clock);
    @(negedge rx_clock);
    n_cmp++; if (ram_wren !== 1'b0) begin n_bad++; $display("FAIL reset_wren got %b exp 0", ram_wren); end
    n_cmp++; if (pkt_ready !== 1'b0) begin n_bad++; $display("FAIL reset_rdy got %b exp 0", pkt_ready); end
    n_cmp++; if (pkt_slot !== 1'b0) begin n_bad++; $display("FAIL reset_slot got %b exp 0", pkt_slot); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_ovr got %b exp 0", overrun); end
    n_cmp++; if (ram_wraddr !== 8'h00) begin n_bad++; $display("FAIL reset_addr got %h exp 00", ram_wraddr); end
    n_cmp++; if (ram_data !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h exp 0", ram_data); end
    n_cmp++; if (debug !== 16'h0) begin n_bad++; $display("FAIL reset_debug got %h exp 0", debug); end
    #1 reset = 1'b0;
  endtask

  task automatic test_basic();
    int n, n0, n1;
    logic [7:0]  ea [12];
    logic [31:0] ed [12];
    n0 = 0; n1 = 0;
    wr_q.delete(); rdy_q.delete();
    enable = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 4; k++) begin
        strobe(16'(k + 1), 16'h0100, (p == 0 ? 32'd1000 : 32'd2000) + 32'(k), 5, n);
        if (k == 3 && p == 0) n0 = n;
        if (k == 3 && p == 1) n1 = n;
        ea[p*6+k] = {p[0], 7'(k + 2)};
        ed[p*6+k] = 32'h0100_0000 + 32'(k + 1);
      end
    ea[4] = 8'h01; ed[4] = 32'd1000;  ea[5]  = 8'h00; ed[5]  = 32'h1000_0010;
    ea[10] = 8'h81; ed[10] = 32'd2000; ea[11] = 8'h80; ed[11] = 32'h0000_0010;
    repeat (6) @(posedge rx_clock);
    @(negedge rx_clock);
    n_cmp++; if (wr_q.size() != 12) begin n_bad++; $display("FAIL basic_nwr got %0d exp 12", wr_q.size()); end
    for (int i = 0; i < 12 && i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i].a !== ea[i] || wr_q[i].d !== ed[i]) begin
        n_bad++; $display("FAIL basic_wr[%0d] got %h:%h exp %h:%h", i, wr_q[i].a, wr_q[i].d, ea[i], ed[i]);
      end
    end
    if (wr_q.size() >= 6) begin
      n_cmp++; if (wr_q[3].cyc != n0 + 1) begin n_bad++; $display("FAIL lat_smp got %0d exp %0d", wr_q[3].cyc, n0 + 1); end
      n_cmp++; if (wr_q[4].cyc != n0 + 2) begin n_bad++; $display("FAIL lat_ts got %0d exp %0d", wr_q[4].cyc, n0 + 2); end
      n_cmp++; if (wr_q[5].cyc != n0 + 3) begin n_bad++; $display("FAIL lat_hdr got %0d exp %0d", wr_q[5].cyc, n0 + 3); end
    end
    n_cmp++; if (rdy_q.size() != 2) begin n_bad++; $display("FAIL basic_nrdy got %0d exp 2", rdy_q.size()); end
    if (rdy_q.size() == 2) begin
      n_cmp++; if (rdy_q[0].cyc != n0 + 4) begin n_bad++; $display("FAIL lat_rdy got %0d exp %0d", rdy_q[0].cyc, n0 + 4); end
      n_cmp++; if (rdy_q[0].s !== 1'b0) begin n_bad++; $display("FAIL basic_slot0 got %b exp 0", rdy_q[0].s); end
      n_cmp++; if (rdy_q[1].s !== 1'b1) begin n_bad++; $display("FAIL basic_slot1 got %b exp 1", rdy_q[1].s); end
      n_cmp++; if (rdy_q[1].cyc != n1 + 4) begin n_bad++; $display("FAIL lat_rdy1 got %0d exp %0d", rdy_q[1].cyc, n1 + 4); end
    end
  endtask

  task automatic test_overrun();
    int n;
    wr_q.delete(); rdy_q.delete();
    strobe(16'h7, 16'h7, 32'd500, 6, n);
    @(negedge rx_clock);
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set got %b exp 1", overrun); end
    n_cmp++; if (wr_q.size() != 0) begin n_bad++; $display("FAIL ovr_nowr got %0d exp 0", wr_q.size()); end
    @(posedge rx_clock); #1;
    free_slots(2'b01);
    for (int k = 0; k < 4; k++) strobe(16'(k + 9), 16'h2, 32'd600 + 32'(k), 5, n);
    @(negedge rx_clock); @(negedge rx_clock); @(negedge rx_clock);
    n_cmp++; if (overrun !== 1'b1 || pkt_ready !== 1'b0) begin n_bad++; $display("FAIL ovr_hold got %b/%b exp 1/0", overrun, pkt_ready); end
    @(negedge rx_clock);
    n_cmp++; if (pkt_ready !== 1'b1 || overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear got rdy %b ovr %b exp 1/0", pkt_ready, overrun); end
    n_cmp++; if (wr_q.size() != 6) begin n_bad++; $display("FAIL ovr_nwr got %0d exp 6", wr_q.size()); end
    if (wr_q.size() == 6) begin
      n_cmp++;
      if (wr_q[5].a !== 8'h00 || wr_q[5].d !== 32'h0400_0010) begin
        n_bad++; $display("FAIL ovr_hdr got %h:%h exp 00:04000010", wr_q[5].a, wr_q[5].d);
      end
    end
    #1 free_slots(2'b11);
  endtask

  task automatic test_eob();
    int n;
    wr_q.delete(); rdy_q.delete();
    strobe(16'h11, 16'h22, 32'd700, 5, n);
    strobe(16'h33, 16'h44, 32'd705, 5, n);
    enable = 1'b0;
    repeat (8) @(posedge rx_clock);
    @(negedge rx_clock);
    n_cmp++; if (wr_q.size() != 4) begin n_bad++; $display("FAIL eob_nwr got %0d exp 4", wr_q.size()); end
    if (wr_q.size() == 4) begin
      n_cmp++; if (wr_q[1].a !== 8'h83 || wr_q[1].d !== 32'h0044_0033) begin n_bad++; $display("FAIL eob_smp got %h:%h exp 83:00440033", wr_q[1].a, wr_q[1].d); end
      n_cmp++; if (wr_q[2].a !== 8'h81 || wr_q[2].d !== 32'd700) begin n_bad++; $display("FAIL eob_ts got %h:%h exp 81:%h", wr_q[2].a, wr_q[2].d, 32'd700); end
      n_cmp++; if (wr_q[3].a !== 8'h80 || wr_q[3].d !== 32'h0800_0008) begin n_bad++; $display("FAIL eob_hdr got %h:%h exp 80:08000008", wr_q[3].a, wr_q[3].d); end
    end
    #1 strobe(16'h55, 16'h66, 32'd800, 4, n);
    repeat (4) @(posedge rx_clock);
    @(negedge rx_clock);
    n_cmp++; if (wr_q.size() != 4 || overrun !== 1'b0) begin n_bad++; $display("FAIL dis_strobe got nwr %0d ovr %b exp 4/0", wr_q.size(), overrun); end
    #1 enable = 1'b1;
    for (int k = 0; k < 4; k++) strobe(16'(k), 16'h9, 32'd900, 5, n);
    repeat (6) @(posedge rx_clock);
    @(negedge rx_clock);
    n_cmp++; if (wr_q.size() != 10) begin n_bad++; $display("FAIL sob_nwr got %0d exp 10", wr_q.size()); end
    if (wr_q.size() == 10) begin
      n_cmp++; if (wr_q[9].a !== 8'h00 || wr_q[9].d !== 32'h1000_0010) begin n_bad++; $display("FAIL sob_hdr got %h:%h exp 00:10000010", wr_q[9].a, wr_q[9].d); end
    end
    n_cmp++; if (rdy_q.size() != 2) begin n_bad++; $display("FAIL eob_nrdy got %0d exp 2", rdy_q.size()); end
    #1 free_slots(2'b11);
  endtask

  task automatic test_reset_mid();
    int n;
    strobe(16'h1, 16'h1, 32'd1, 5, n);
    strobe(16'h2, 16'h2, 32'd2, 5, n);
    reset = 1'b1;
    repeat (2) @(posedge rx_clock);
    #1 reset = 1'b0;
    wr_q.delete(); rdy_q.delete();
    repeat (10) @(posedge rx_clock);
    @(negedge rx_clock);
    n_cmp++; if (rdy_q.size() != 0 || wr_q.size() != 0) begin n_bad++; $display("FAIL rstmid_quiet got rdy %0d wr %0d exp 0/0", rdy_q.size(), wr_q.size()); end
    n_cmp++; if (debug[15:10] !== 6'b0) begin n_bad++; $display("FAIL rstmid_state got %b exp 000000", debug[15:10]); end
    #1;
    for (int k = 0; k < 4; k++) strobe(16'(k + 3), 16'h3, 32'd3333, 5, n);
    repeat (6) @(posedge rx_clock);
    @(negedge rx_clock);
    n_cmp++; if (wr_q.size() != 6) begin n_bad++; $display("FAIL rstmid_nwr got %0d exp 6", wr_q.size()); end
    if (wr_q.size() == 6) begin
      n_cmp++; if (wr_q[0].a !== 8'h02) begin n_bad++; $display("FAIL rstmid_addr got %h exp 02", wr_q[0].a); end
      n_cmp++; if (wr_q[5].a !== 8'h00 || wr_q[5].d !== 32'h1000_0010) begin n_bad++; $display("FAIL rstmid_hdr got %h:%h exp 00:10000010", wr_q[5].a, wr_q[5].d); end
    end
    n_cmp++; if (rdy_q.size() != 1 || (rdy_q.size() == 1 && rdy_q[0].s !== 1'b0)) begin n_bad++; $display("FAIL rstmid_slot got n=%0d exp one pkt on slot 0", rdy_q.size()); end
  endtask

  // Reference: each burst of ns samples splits into ceil(ns/PK) packets on
  // alternating slots; first of burst carries SOB, a short tail carries EOB.
  task automatic test_random();
    wr_t         exp_wr[$];
    logic        exp_rdy[$];
    logic [31:0] sd[$], st[$];
    logic [31:0] d, t, hdr;
    logic        mcur;
    int          n, ns, lo, m;
    reset = 1'b1; enable = 1'b0;
    repeat (3) @(posedge rx_clock);
    #1 reset = 1'b0; auto_free = 1'b1;
    wr_q.delete(); rdy_q.delete();
    mcur = 1'b0; lo = 3;
    for (int b = 0; b < 14; b++) begin
      sd.delete(); st.delete();
      ns = $urandom_range(1, 10);
      enable = 1'b1;
      for (int k = 0; k < ns; k++) begin
        d = $urandom; t = $urandom;
        strobe(d[15:0], d[31:16], t, (k == 0) ? int'($urandom_range(4 - lo, 6)) : int'($urandom_range(4, 7)), n);
        sd.push_back(d); st.push_back(t);
      end
      enable = 1'b0;
      lo = $urandom_range(1, 3);
      repeat (lo) @(posedge rx_clock);
      #1;
      for (int p = 0; p * PK < ns; p++) begin
        m = (ns - p * PK > PK) ? PK : ns - p * PK;
        for (int k = 0; k < m; k++) exp_wr.push_back('{0, {mcur, 7'(k + 2)}, sd[p*PK+k]});
        exp_wr.push_back('{0, {mcur, 7'd1}, st[p*PK]});
        hdr = (p == 0 ? 32'h1000_0000 : 32'h0) | (m < PK ? 32'h0800_0000 : 32'h0)
            | (32'(CH) << 16) | (32'(m) << 2);
        exp_wr.push_back('{0, {mcur, 7'd0}, hdr});
        exp_rdy.push_back(mcur);
        mcur = ~mcur;
      end
    end
    repeat (30) @(posedge rx_clock);
    @(negedge rx_clock);
    n_cmp++; if (wr_q.size() != exp_wr.size()) begin n_bad++; $display("FAIL rand_nwr got %0d exp %0d", wr_q.size(), exp_wr.size()); end
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i].a !== exp_wr[i].a || wr_q[i].d !== exp_wr[i].d) begin
        n_bad++; $display("FAIL rand_wr[%0d] got %h:%h exp %h:%h", i, wr_q[i].a, wr_q[i].d, exp_wr[i].a, exp_wr[i].d);
      end
    end
    n_cmp++; if (rdy_q.size() != exp_rdy.size()) begin n_bad++; $display("FAIL rand_nrdy got %0d exp %0d", rdy_q.size(), exp_rdy.size()); end
    for (int i = 0; i < exp_rdy.size() && i < rdy_q.size(); i++) begin
      n_cmp++;
      if (rdy_q[i].s !== exp_rdy[i]) begin n_bad++; $display("FAIL rand_slot[%0d] got %b exp %b", i, rdy_q[i].s, exp_rdy[i]); end
    end
    auto_free = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; rx_strobe = 1'b0; rx_i = '0; rx_q = '0;
    adc_time = '0; man_fv = 2'b00; auto_free = 1'b0;
    test_reset();
    test_basic();
    test_overrun();
    test_eob();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/chan_fifo_writer.md
CHAN_FIFO_WRITER -- requirements
Module: chan_fifo_writer

Interface
REQ-001 SHALL have parameter PKT_SAMPLES, default 126: samples per full packet (legal range 1..126).
REQ-002 SHALL have parameter CHANNEL, default 5'd0: channel number placed in the header.
REQ-003 SHALL have port rx_clock, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-005 SHALL have port enable, input, 1 bit: burst gate; samples are captured only while high.
REQ-006 SHALL have port rx_strobe, input, 1 bit: one-cycle sample-valid pulse, spaced at least 4 clocks apart.
REQ-007 SHALL have ports rx_i and rx_q, input, 16 bits each: sample components, valid with rx_strobe.
REQ-008 SHALL have port adc_time, input, 32 bits: current sample time.
REQ-009 SHALL have port slot_free, input, 2 bits: one-cycle pulse per slot from the consumer releasing that slot.
REQ-010 SHALL have port ram_wraddr, output, 8 bits: {slot, offset[6:0]}.
REQ-011 SHALL have port ram_data, output, 32 bits: RAM write data.
REQ-012 SHALL have port ram_wren, output, 1 bit: RAM write enable.
REQ-013 SHALL have port pkt_ready, output, 1 bit: one-cycle pulse when a packet is complete.
REQ-014 SHALL have port pkt_slot, output, 1 bit: slot of the completed packet, valid with pkt_ready.
REQ-015 SHALL have port overrun, output, 1 bit: high from a dropped sample until the next pkt_ready.
REQ-016 SHALL have port debug, output, 16 bits: {state[2:0], slot_busy[1:0], cur_slot, count[6:0], enable, rx_strobe, ram_wren}.

Function
REQ-017 SHALL use packet layout: offset 0 header, offset 1 timestamp, offsets 2..(1+n) samples.
REQ-018 SHALL form each sample word as {rx_q, rx_i}, with I in bits 15:0.
REQ-019 SHALL form the header as: [28] start-of-burst; [27] end-of-burst; [26] overrun-since-last-commit; [20:16] CHANNEL; [8:2] sample count n; all other bits 0.
REQ-020 SHALL set the timestamp word to adc_time sampled on the rx_strobe cycle of the packet's first sample.
REQ-021 SHALL implement states IDLE, FILL, WR_TS, WR_HDR and COMMIT; all outputs SHALL be registered.
REQ-022 IDLE: on rx_strobe with enable=1 and slot_busy[cur_slot]=0: write the sample at offset 2, capture the timestamp, set slot_busy[cur_slot], set count=1, go to FILL.
REQ-023 IDLE: on rx_strobe with enable=1 and slot_busy[cur_slot]=1: drop the sample, set overrun and the internal ovr flag, do not write.
REQ-024 FILL: on rx_strobe with enable=1: write at offset 2+count and increment count; when count reaches PKT_SAMPLES, go to WR_TS.
REQ-025 FILL: when enable=0 and no strobe is present, set the eob flag and go to WR_TS; count is always ≥1 at this point.
REQ-026 WR_TS SHALL write the timestamp at offset 1, then go to WR_HDR.
REQ-027 WR_HDR SHALL write the header at offset 0, then go to COMMIT.
REQ-028 COMMIT SHALL pulse pkt_ready with pkt_slot=cur_slot, toggle cur_slot, clear the ovr/eob flags, clear overrun, and return to IDLE.
REQ-029 Latency: with a final-sample strobe at cycle N, the sample write SHALL occur at N+1, timestamp at N+2, header at N+3, and pkt_ready at N+4.
REQ-030 Start-of-burst SHALL be set on the first packet after enable rises or after reset, and clear on subsequent packets of the burst.
REQ-031 A sample strobe arriving during WR_TS, WR_HDR or COMMIT SHALL be held in a 1-entry pending register and processed as if it arrived in IDLE on the cycle COMMIT exits.
REQ-032 slot_free[i] SHALL clear slot_busy[i] on the next edge; if it coincides with a set of the same slot, the set SHALL win.
REQ-033 count SHALL be 7 bits and SHALL never exceed PKT_SAMPLES; ram_wraddr offset = count+2 SHALL never wrap.
REQ-034 A sample strobe with enable=0 SHALL be ignored without setting overrun.

Reset
REQ-035 On reset, state SHALL be IDLE; cur_slot, slot_busy, count, and the ovr/eob/pending flags SHALL be 0; the SOB flag SHALL be 1.
REQ-036 On reset, ram_wren, pkt_ready, pkt_slot, overrun, ram_wraddr and ram_data SHALL be 0.
REQ-037 Reset mid-packet SHALL discard the partial packet: no pkt_ready, and both slots free.

Verification
REQ-038 With PKT_SAMPLES=4, enable=1, and 4 strobes I=1..4, Q=0x100 (adc_time=1000 at the first) -> writes at 0x02..0x05 with data 0x01000001..0x01000004, 0x01=1000, 0x00=0x10000010, then pkt_ready with pkt_slot=0.
REQ-039 A second 4-sample packet -> writes at 0x82..0x85, header 0x00000010 at 0x80, pkt_slot=1.
REQ-040 enable falls after 2 samples -> header 0x08000008 (SOB clear within the burst, EOB set, n=2); next burst header has bit 28 set.
REQ-041 Both slots busy plus one strobe -> no ram_wren, overrun=1; after slot_free=01 the next header has bit 26 set and overrun clears at pkt_ready.
REQ-042 Reset asserted mid-FILL -> no pkt_ready; next packet goes to slot 0 with header bit 28 set.
